uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- 8N1 UART receiver: recovers bytes from the asynchronous serial input `rxd` and presents them on a valid/ready byte interface.
- Receive-side companion to the team's baud divider/transmit path; carries host command bytes into the ADC control logic.
- Contains its own oversampling tick generator. Start-bit validation, mid-bit sampling, framing-error and overrun detection.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Must be even and ≥ 4.
- TICK_DIV, derived = round(CLK_FREQ/(BAUD*OVERSAMPLE)), min 1: clocks per tick. Not user-set.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idle high.
- m_data  out  8  received byte; stable while m_valid=1.
- m_valid  out  1  byte available.
- m_ready  in  1  consumer accepts; transfer occurs when m_valid&m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte completed while holding register full.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - m_data=0, m_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops = 1. State = IDLE. Tick and sample counters = 0.
- Input path:
  - Two-flop synchronizer on rxd, giving rxd_s (2-clk latency). All decisions use rxd_s.
- Tick generator:
  - Counts 0..TICK_DIV-1 and emits one-cycle tick at terminal count.
  - Synchronously cleared on entry to START, so sample phase is aligned to the detected edge.
  - Runs only when state≠IDLE.
- FSM, sample counter s counts ticks:
  - IDLE: rxd_s==0 (falling edge, previous rxd_s=1) → START, s=0.
  - START: at tick with s==OVERSAMPLE/2-1 sample rxd_s.
    - 1 → IDLE (glitch rejected, no flags).
    - 0 → DATA, s=0, bit index=0.
  - DATA: at tick with s==OVERSAMPLE-1 sample rxd_s into shift register, LSB first; s=0.
    - After bit index 7 → STOP.
  - STOP: at tick with s==OVERSAMPLE-1 sample rxd_s.
    - 1 → deliver byte (see below), → IDLE.
    - 0 → frame_err pulse, byte discarded, → BREAK.
  - BREAK: wait for rxd_s==1, then → IDLE. Prevents a held-low line retriggering start.
- Delivery:
  - Byte is written to m_data and m_valid=1 on the clock after the stop sample.
  - m_valid stays high until a cycle with m_ready=1; it then clears unless a new byte delivers in the same cycle.
- Simultaneous events:
  - Delivery in the same cycle as m_valid&m_ready: new byte loaded, m_valid stays 1, no overrun.
  - Delivery while m_valid&!m_ready: new byte dropped, m_data unchanged, overrun pulses 1 cycle.
- rst mid-byte: FSM returns to IDLE next clock, partial byte discarded, no flags. Any pending m_valid is cleared.
- Tolerance: correct reception for a transmitter baud error of ±3% at OVERSAMPLE=16.
- Width rules:
  - Tick counter width = clog2(TICK_DIV); TICK_DIV=1 means tick every cycle.
  - Sample counter width = clog2(OVERSAMPLE); bit index 3 bits.

Decomposition:
- Package uart_pkg:
  - State enum {IDLE, START, DATA, STOP, BREAK}.
  - Function computing TICK_DIV with rounding and min-1 clamp.
  - Constant DATA_BITS=8.
- One sub-module: uart_baud_tick, with ports clk, rst, en, clr, tick.
  - The team's transmit path reuses it at OVERSAMPLE=1.

Test Plan:
- Bench parameters: CLK_FREQ=3200000, BAUD=100000, OVERSAMPLE=16 (TICK_DIV=2, 32 clk/bit).
- Reset: rst=1 for 4 clk, rxd=1 → m_valid=0, busy=0, frame_err=0, overrun=0, m_data=0x00.
- Byte: send 0xA5 with m_ready=1 → m_data=0xA5, m_valid high exactly 1 cycle, ~2+16+8*32+32 clk after start edge; busy=0 after.
- Glitch: rxd low 8 clk then high → busy returns to 0, no m_valid, no frame_err.
- Framing: send 0x3C with stop bit=0, hold rxd low 200 clk → one frame_err pulse, no m_valid; then raise rxd and send 0x81 → m_data=0x81 received.
- Overrun: m_ready=0, send 0x11 then 0x22 → m_data=0x11, one overrun pulse at second stop; raise m_ready 1 cycle → m_valid=0.
- Reset mid-byte: rst pulse during bit 4 of 0xFF → no m_valid; next 0x5A sent at BAUD+3% → m_data=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  // Clocks per oversampling tick, rounded to nearest and never below one.
  function automatic int calc_tick_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV enabled clocks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (DIV > 1) begin : g_cnt
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end

    assign tick = en && !clr && (cnt == LAST);
  end else begin : g_every
    assign tick = en && !clr;
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with oversampled mid-bit sampling, framing and overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t state, state_next;

  logic rxd_meta, rxd_s, rxd_prev;
  logic tick, tick_en, tick_clr;
  logic [SW-1:0] s;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic start_fall, mid_sample, end_sample, deliver, stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign start_fall = rxd_prev && !rxd_s;

  // Tick phase restarts at the detected start edge so samples land mid-bit.
  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_fall) state_next = START;
      START:   if (mid_sample) state_next = rxd_s ? IDLE : DATA;
      DATA:    if (end_sample && bit_idx == LAST_BIT) state_next = STOP;
      STOP:    if (end_sample) state_next = rxd_s ? IDLE : BREAK;
      BREAK:   if (rxd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    tick_en    = (state != IDLE);
    tick_clr   = (state == IDLE) && start_fall;
    mid_sample = (state == START) && tick && (s == S_MID);
    end_sample = ((state == DATA) || (state == STOP)) && tick && (s == S_LAST);
    deliver    = (state == STOP) && end_sample && rxd_s;
    stop_bad   = (state == STOP) && end_sample && !rxd_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;

      if (state == IDLE) begin
        s       <= '0;
        bit_idx <= '0;
      end else if (tick && state != BREAK) begin
        if (mid_sample || end_sample) s <= '0;
        else                          s <= s + SW'(1);
      end

      if (state == DATA && end_sample) begin
        shift   <= {rxd_s, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      // A byte completing against an unaccepted holding register is dropped.
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (deliver) begin
        if (m_valid && !m_ready) begin
          overrun <= 1'b1;
        end else begin
          m_data  <= shift;
          m_valid <= 1'b1;
        end
      end
    end
  end

endmodule
